button_event_scheduler: RTL and testbench
=========================================

# button_event_scheduler

Converts debounced push-button levels into a single serialized stream of press and long-press events with a valid/ready handshake. Each debounced input is edge-detected and hold-timed. Pending events are shared onto one output slot by a round-robin arbiter. The block sits between the per-button debouncer instances and the pattern-checking FSM, which consumes one event at a time.

## Interface
- `NUM_BTNS`, default 4: number of button inputs; must be at least 2.
- `HOLD_CYCLES`, default 50_000_000: cycles a level must stay high to post a long-press event; must be at least 2.
- `ID_W`, derived localparam `$clog2(NUM_BTNS)`: width of the event id.
- `CNT_W`, derived localparam `$clog2(HOLD_CYCLES+1)`: width of each hold counter.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `btn_lvl`  in  NUM_BTNS  debounced button levels, already synchronous to `clk`.
- `evt_ready`  in  1  consumer accepts the event when `evt_valid` is also high.
- `evt_valid`  out  1  output slot holds an event.
- `evt_id`  out  ID_W  index of the button that produced the event.
- `evt_long`  out  1  0 means a press event; 1 means a long-press event.
- `ovf`  out  1  sticky flag: an event was dropped.
- `ovf_clr`  in  1  clears `ovf`.

## Operation
- **Edge detect:** `prev[i]` is a registered copy of `btn_lvl[i]`. A press edge is `btn_lvl[i] & ~prev[i]`, and it sets `press_pend[i]`.
- **Hold counter `hcnt[i]`:**
  - Cleared whenever `btn_lvl[i]` is 0.
  - Increments while `btn_lvl[i]` is 1, saturating at HOLD_CYCLES.
  - The cycle it steps from HOLD_CYCLES-1 to HOLD_CYCLES, it sets `long_pend[i]`.
  - Result: exactly one long event per continuous hold.
- **Request vector:** `req[i] = press_pend[i] | long_pend[i]`.
  - If both are pending for one button, the press event is issued first.
- **Output slot states:**
  - EMPTY (`evt_valid`=0) and FULL (`evt_valid`=1).
  - Load is enabled when EMPTY, or when FULL and `evt_ready`=1. A handshake and a reload may happen in the same cycle.
  - On load with any `req` set: grant the first requester at or after `last+1`, wrapping modulo NUM_BTNS. Register its id and kind, clear that pending bit, and set `last` to the granted index. The slot is FULL.
  - On load with no `req`: the slot goes EMPTY.
  - While FULL without `evt_ready`: `evt_id` and `evt_long` are held stable.
- **Overflow:**
  - A new press edge while `press_pend[i]` is already set and not being granted this cycle: the event is dropped and `ovf` is set.
  - The same rule applies to a new long trigger while `long_pend[i]` is set.
- **Simultaneous events:**
  - Grant of bit i in the same cycle as a new trigger on bit i: the bit stays 1 and no overflow is flagged.
  - `ovf_clr` in the same cycle as a new drop: `ovf` stays 1 (set wins).
- **Reset (`rst_n`=0 at an edge):**
  - Outputs: `evt_valid`=0, `evt_id`=0, `evt_long`=0, `ovf`=0.
  - Internal state: `prev`, `press_pend`, `long_pend` and `hcnt` all zero; `last`=NUM_BTNS-1, so button 0 has first priority.
  - An in-flight event is discarded.
  - A button held high through reset produces a press edge on the first cycle after release.

## Timing
- **Press latency:** `btn_lvl[i]` is first sampled high at edge k. `press_pend[i]` is set at edge k. With the slot free, `evt_valid` rises after edge k+1 (2 cycles).
- **Long-press:** `hcnt` reaches HOLD_CYCLES at edge k+HOLD_CYCLES-1, and `long_pend` is set at that same edge. `evt_valid` for the long event rises no earlier than the following edge.
- **Throughput:** one event per cycle while `evt_ready` is held at 1.
- Everything is registered; no combinational path from `btn_lvl` to any output.
- `evt_ready` affects the slot only at the next edge. Outputs never depend combinationally on `evt_ready`.

## Structure
- **Package `btn_evt_pkg`:** event-kind enum `EVT_PRESS`=0, `EVT_LONG`=1, plus the default HOLD_CYCLES constant.
- **Sub-module `rr_arbiter`** (parameter N; ports `req`, `last`, `grant_vld`, `grant_idx`): a purely combinational rotate-and-priority-encode, reusable elsewhere.
- Per-button edge detect, hold counters and pending bits live in a generate loop in the top module.

## Test plan
- **Single press:** NUM_BTNS=4, `evt_ready`=1, `btn_lvl`=0010 for 5 cycles -> one beat with `evt_id`=1, `evt_long`=0, valid 2 cycles after the first sampled-high edge.
- **Long press:** HOLD_CYCLES=8; hold `btn_lvl[2]` high 20 cycles -> press beat (id 2) followed by exactly one long beat (id 2, `evt_long`=1); nothing further until release and re-press.
- **Round-robin fairness:** `evt_ready`=0 while buttons 0, 1 and 3 press simultaneously; then `evt_ready`=1 -> ids in order 0, 1, 3.
  - Repeat with `last`=1 from the previous run -> ids 3, 0, 1.
- **Backpressure and overflow:** `evt_ready`=0; press button 1, release, press again, while a press from button 0 occupies the slot -> `ovf`=1; after `evt_ready`=1 exactly one id-1 press is delivered.
  - `ovf_clr` then clears `ovf`.
- **Simultaneous grant and new edge:** arrange a button-2 press edge in the same cycle its pending bit is granted -> two id-2 beats delivered, `ovf` stays 0.
- **Reset mid-operation:** assert `rst_n`=0 while `evt_valid`=1 and pending bits are set -> next cycle `evt_valid`=0, `evt_id`=0, `ovf`=0. After release, with buttons low, no events are produced.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared types and defaults for the button event scheduler.
package btn_evt_pkg;

  typedef enum logic {
    EVT_PRESS = 1'b0,
    EVT_LONG  = 1'b1
  } evt_kind_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One second of hold at a 50 MHz clock.
  localparam int DEFAULT_HOLD_CYCLES = 50_000_000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// last+1, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 grant_vld,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int W = $clog2(N);

  logic [W-1:0] cand;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int off = N; off >= 1; off--) begin
      cand = W'((int'(last) + off) % N);
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into a serialized press / long-press event
// stream on a single valid/ready output slot.
module button_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter  int NUM_BTNS    = 4,
  parameter  int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  localparam int ID_W        = $clog2(NUM_BTNS),
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_lvl,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [ID_W-1:0]     evt_id,
  output logic                evt_long,
  output logic                ovf,
  input  logic                ovf_clr
);

  logic [NUM_BTNS-1:0] prev_reg;
  logic [NUM_BTNS-1:0] press_pend_reg;
  logic [NUM_BTNS-1:0] long_pend_reg;
  logic [CNT_W-1:0]    hcnt_reg [NUM_BTNS];

  logic [NUM_BTNS-1:0] press_edge;
  logic [NUM_BTNS-1:0] long_trig;
  logic [NUM_BTNS-1:0] grant_press;
  logic [NUM_BTNS-1:0] grant_long;
  logic [NUM_BTNS-1:0] drop;
  logic [NUM_BTNS-1:0] req;

  logic                load;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     last_reg;

  slot_state_e         state_reg;
  logic [ID_W-1:0]     id_reg;
  evt_kind_e           kind_reg;
  logic                ovf_reg;

  assign load = (state_reg == SLOT_EMPTY) | evt_ready;
  assign req  = press_pend_reg | long_pend_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : gen_btn
      logic hit;

      assign press_edge[gi]  = btn_lvl[gi] & ~prev_reg[gi];
      assign long_trig[gi]   = btn_lvl[gi] & (hcnt_reg[gi] == CNT_W'(HOLD_CYCLES - 1));
      assign hit             = load & grant_vld & (grant_idx == ID_W'(gi));
      // A pending press always goes out before a pending long for the same button.
      assign grant_press[gi] = hit & press_pend_reg[gi];
      assign grant_long[gi]  = hit & ~press_pend_reg[gi] & long_pend_reg[gi];
      assign drop[gi]        = (press_edge[gi] & press_pend_reg[gi] & ~grant_press[gi])
                             | (long_trig[gi] & long_pend_reg[gi] & ~grant_long[gi]);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          prev_reg[gi]       <= 1'b0;
          press_pend_reg[gi] <= 1'b0;
          long_pend_reg[gi]  <= 1'b0;
          hcnt_reg[gi]       <= '0;
        end else begin
          prev_reg[gi]       <= btn_lvl[gi];
          press_pend_reg[gi] <= press_edge[gi] | (press_pend_reg[gi] & ~grant_press[gi]);
          long_pend_reg[gi]  <= long_trig[gi] | (long_pend_reg[gi] & ~grant_long[gi]);
          if (!btn_lvl[gi]) begin
            hcnt_reg[gi] <= '0;
          end else if (hcnt_reg[gi] != CNT_W'(HOLD_CYCLES)) begin
            hcnt_reg[gi] <= hcnt_reg[gi] + 1'b1;
          end
        end
      end
    end
  endgenerate

  rr_arbiter #(
    .N(NUM_BTNS)
  ) u_arb (
    .req       (req),
    .last      (last_reg),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= SLOT_EMPTY;
      id_reg    <= '0;
      kind_reg  <= EVT_PRESS;
      last_reg  <= ID_W'(NUM_BTNS - 1);
    end else if (load) begin
      if (grant_vld) begin
        state_reg <= SLOT_FULL;
        id_reg    <= grant_idx;
        kind_reg  <= press_pend_reg[grant_idx] ? EVT_PRESS : EVT_LONG;
        last_reg  <= grant_idx;
      end else begin
        state_reg <= SLOT_EMPTY;
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (|drop) begin
      ovf_reg <= 1'b1;
    end else if (ovf_clr) begin
      ovf_reg <= 1'b0;
    end
  end

  assign evt_valid = (state_reg == SLOT_FULL);
  assign evt_id    = id_reg;
  assign evt_long  = (kind_reg == EVT_LONG);
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler (4 buttons, HOLD_CYCLES=8).
// Delivered beats are logged as long*4 + id.
module tb_button_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_lvl;
  logic       evt_ready;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_long;
  logic       ovf;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_err = 0;
  int beats[$];

  button_event_scheduler #(
    .NUM_BTNS    (4),
    .HOLD_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_lvl   (btn_lvl),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_long  (evt_long),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // A beat transfers at the next rising edge when valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      beats.push_back(int'(evt_long) * 4 + int'(evt_id));
      $display("beat: id=%0d long=%0d ovf=%0d", evt_id, evt_long, ovf);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_beats(input string tag, input int n,
                           input int e0 = 0, input int e1 = 0,
                           input int e2 = 0, input int e3 = 0);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_count"}, beats.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < beats.size()) chk($sformatf("%s_beat%0d", tag, i), beats[i], e[i]);
    end
    beats.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    btn_lvl = 4'b0000;
    tick(3);
    rst_n = 1'b1;
    beats.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    btn_lvl   = 4'b0000;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick(3);
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_id",    int'(evt_id),    0);
    chk("rst_long",  int'(evt_long),  0);
    chk("rst_ovf",   int'(ovf),       0);
    rst_n = 1'b1;

    // Single press: valid two edges after the first sampled-high edge.
    evt_ready = 1'b1;
    btn_lvl   = 4'b0010;
    tick();
    chk("press_lat1_valid", int'(evt_valid), 0);
    tick();
    chk("press_lat2_valid", int'(evt_valid), 1);
    chk("press_id",         int'(evt_id),    1);
    chk("press_long",       int'(evt_long),  0);
    tick(3);
    btn_lvl = 4'b0000;
    tick(3);
    chk_beats("single", 1, 1);

    // Long press: one press beat then exactly one long beat.
    btn_lvl = 4'b0100;
    tick(20);
    btn_lvl = 4'b0000;
    tick(4);
    chk_beats("long", 2, 2, 6);
    chk("long_ovf", int'(ovf), 0);

    // Round robin from reset priority: 0, 1, 3.
    do_reset();
    evt_ready = 1'b0;
    btn_lvl   = 4'b1011;
    tick(2);
    btn_lvl = 4'b0000;
    chk("rr_hold_valid", int'(evt_valid), 1);
    chk("rr_hold_id0",   int'(evt_id),    0);
    tick(2);
    chk("rr_hold_id1",   int'(evt_id),    0);
    evt_ready = 1'b1;
    tick(5);
    chk_beats("rr_a", 3, 0, 1, 3);

    // Put last at 1, then the same burst comes out as 3, 0, 1.
    btn_lvl = 4'b0010;
    tick(2);
    btn_lvl = 4'b0000;
    tick(4);
    evt_ready = 1'b0;
    btn_lvl   = 4'b1011;
    tick(2);
    btn_lvl = 4'b0000;
    tick(3);
    evt_ready = 1'b1;
    tick(5);
    chk_beats("rr_b", 4, 1, 3, 0, 1);

    // Backpressure: second press of button 1 is dropped.
    evt_ready = 1'b0;
    btn_lvl   = 4'b0001;
    tick(2);
    chk("bp_slot_id", int'(evt_id), 0);
    btn_lvl = 4'b0011;
    tick();
    chk("bp_ovf_before", int'(ovf), 0);
    btn_lvl = 4'b0001;
    tick();
    btn_lvl = 4'b0011;
    tick();
    chk("bp_ovf_set", int'(ovf), 1);
    btn_lvl   = 4'b0000;
    tick();
    evt_ready = 1'b1;
    tick(4);
    chk_beats("bp", 2, 0, 1);
    chk("bp_ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("bp_ovf_clr", int'(ovf), 0);

    // New button-2 edge on the very edge its pending bit is granted.
    evt_ready = 1'b0;
    btn_lvl   = 4'b0001;
    tick(2);
    btn_lvl = 4'b0101;
    tick();
    btn_lvl = 4'b0001;
    tick();
    btn_lvl   = 4'b0101;
    evt_ready = 1'b1;
    tick();
    chk("sim_ovf", int'(ovf), 0);
    btn_lvl = 4'b0000;
    tick(4);
    chk_beats("sim", 3, 0, 2, 2);
    chk("sim_ovf_end", int'(ovf), 0);

    // Reset with a full slot, pending bits and overflow set.
    evt_ready = 1'b0;
    btn_lvl   = 4'b1011;
    tick(2);
    chk("mid_valid", int'(evt_valid), 1);
    chk("mid_id",    int'(evt_id),    3);
    btn_lvl = 4'b0000;
    tick();
    btn_lvl = 4'b1011;
    tick();
    chk("mid_ovf", int'(ovf), 1);
    rst_n   = 1'b0;
    btn_lvl = 4'b0000;
    tick();
    chk("mrst_valid", int'(evt_valid), 0);
    chk("mrst_id",    int'(evt_id),    0);
    chk("mrst_ovf",   int'(ovf),       0);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    beats.delete();
    tick(10);
    chk_beats("idle", 0);

    // Button held through reset gives a press right after release.
    rst_n   = 1'b0;
    btn_lvl = 4'b0001;
    tick();
    rst_n = 1'b1;
    tick();
    chk("held_lat1_valid", int'(evt_valid), 0);
    tick();
    chk("held_valid", int'(evt_valid), 1);
    chk("held_id",    int'(evt_id),    0);
    btn_lvl = 4'b0000;
    tick(3);
    chk_beats("held", 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
